rotate_shift_pipe: RTL and testbench

Two-stage pipelined barrel rotator/shifter with valid/ready handshakes on input and output. It is the parametrised successor of the 32-bit combinational rotate.
- Generalises data width.
- Supports right/left rotate plus logical and arithmetic shifts.
- Carries a tag through the pipe for out-of-order bookkeeping in the execute stage.
- Sits between operand fetch and writeback in the ALU datapath.

---
 rtl/rotate_pkg.sv | 21 ++
 rtl/rot_mux_level.sv | 23 ++
 rtl/rotate_shift_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_rotate_shift_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotate_pkg.sv
// Shared definitions for the pipelined rotator/shifter: op codes, widths and
// the ROL-to-ROR amount normalisation.
package rotate_pkg;

  localparam int ROT_OP_W          = 3;
  localparam int ROT_DEFAULT_WIDTH = 32;

  typedef enum logic [ROT_OP_W-1:0] {
    OP_ROR = 3'b000,
    OP_ROL = 3'b001,
    OP_SRL = 3'b010,
    OP_SLL = 3'b011,
    OP_SRA = 3'b100
  } rot_op_e;

  // A left rotate by n equals a right rotate by (width - n) mod width.
  function automatic logic [7:0] rol_to_ror_amt(input logic [7:0] amt, input int unsigned width);
    return 8'((width - 32'(amt)) % width);
  endfunction

endpackage

// File: rtl/rot_mux_level.sv
// One barrel level: conditionally moves data right by 2**LEVEL, either
// rotating or filling the vacated MSBs with i_fill.
module rot_mux_level #(
  parameter int WIDTH = 32,
  parameter int LEVEL = 0
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_amt_bit,
  input  logic             i_fill,
  input  logic             i_rotate,
  output logic [WIDTH-1:0] o_data
);

  localparam int STEP = 1 << LEVEL;

  logic [WIDTH-1:0] w_rot;
  logic [WIDTH-1:0] w_shr;

  assign w_rot  = {i_data[STEP-1:0], i_data[WIDTH-1:STEP]};
  assign w_shr  = {{STEP{i_fill}}, i_data[WIDTH-1:STEP]};
  assign o_data = !i_amt_bit ? i_data : (i_rotate ? w_rot : w_shr);

endmodule

// File: rtl/rotate_shift_pipe.sv
// Two-stage valid/ready barrel rotator/shifter with a pass-through tag.
// Optional result flags (out_zero/out_carry) are built when ROT_FLAGS_EN is defined.
module rotate_shift_pipe
  import rotate_pkg::*;
#(
  parameter int  WIDTH = ROT_DEFAULT_WIDTH,
  parameter int  TAG_W = 4,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ROT_OP_W-1:0] in_op,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [AMT_W-1:0]    in_amt,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
`ifdef ROT_FLAGS_EN
  output logic                out_zero,
  output logic                out_carry,
`endif
  output logic [TAG_W-1:0]    out_tag
);

  localparam int SPLIT = AMT_W / 2;

  // Everything is executed as a right move; SLL reverses the operand on the
  // way in and the result on the way out.
  logic             w_in_rotate;
  logic             w_in_reverse;
  logic             w_in_fill;
  logic [AMT_W-1:0] w_in_amt;
  logic [WIDTH-1:0] w_in_rev;
  logic [WIDTH-1:0] w_in_data;

  always_comb begin
    w_in_rotate  = 1'b0;
    w_in_reverse = 1'b0;
    w_in_fill    = 1'b0;
    w_in_amt     = in_amt;
    case (rot_op_e'(in_op))
      OP_ROR: w_in_rotate = 1'b1;
      OP_ROL: begin
        w_in_rotate = 1'b1;
        w_in_amt    = AMT_W'(rol_to_ror_amt(8'(in_amt), WIDTH));
      end
      OP_SRL: w_in_fill = 1'b0;
      OP_SLL: w_in_reverse = 1'b1;
      OP_SRA: w_in_fill = in_a[WIDTH-1];
      default: w_in_amt = '0;
    endcase
  end

  logic [WIDTH-1:0] w_s1_chain [SPLIT:AMT_W];
  logic [WIDTH-1:0] w_s2_chain [0:SPLIT];
  logic [WIDTH-1:0] w_s2_rev;
  logic [WIDTH-1:0] w_s2_result;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic [SPLIT-1:0] r_s1_amt_lo;
  logic             r_s1_fill;
  logic             r_s1_rotate;
  logic             r_s1_reverse;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [TAG_W-1:0] r_out_tag;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign w_in_rev[gi] = in_a[WIDTH-1-gi];
      assign w_s2_rev[gi] = w_s2_chain[0][WIDTH-1-gi];
    end

    for (gi = AMT_W - 1; gi >= SPLIT; gi--) begin : g_s1_lvl
      rot_mux_level #(.WIDTH(WIDTH), .LEVEL(gi)) u_lvl (
        .i_data   (w_s1_chain[gi+1]),
        .i_amt_bit(w_in_amt[gi]),
        .i_fill   (w_in_fill),
        .i_rotate (w_in_rotate),
        .o_data   (w_s1_chain[gi])
      );
    end

    for (gi = SPLIT - 1; gi >= 0; gi--) begin : g_s2_lvl
      rot_mux_level #(.WIDTH(WIDTH), .LEVEL(gi)) u_lvl (
        .i_data   (w_s2_chain[gi+1]),
        .i_amt_bit(r_s1_amt_lo[gi]),
        .i_fill   (r_s1_fill),
        .i_rotate (r_s1_rotate),
        .o_data   (w_s2_chain[gi])
      );
    end
  endgenerate

  assign w_in_data          = w_in_reverse ? w_in_rev : in_a;
  assign w_s1_chain[AMT_W]  = w_in_data;
  assign w_s2_chain[SPLIT]  = r_s1_data;
  assign w_s2_result        = r_s1_reverse ? w_s2_rev : w_s2_chain[0];

  logic w_s2_ready;
  logic w_s1_ready;

  assign w_s2_ready = !r_s2_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign in_ready   = w_s1_ready;
  assign out_valid  = r_s2_valid;
  assign out_data   = r_out_data;
  assign out_tag    = r_out_tag;

`ifdef ROT_FLAGS_EN
  // Carry source: 0 none, 1 result MSB (ROR), 2 result LSB (ROL), 3 bit shifted out.
  logic [1:0] w_in_cmode;
  logic       w_in_cbit;
  logic [1:0] r_s1_cmode;
  logic       r_s1_cbit;
  logic       r_out_zero;
  logic       r_out_carry;
  logic       w_s2_carry;

  always_comb begin
    w_in_cmode = 2'd0;
    w_in_cbit  = w_in_data[w_in_amt - AMT_W'(1)];
    if (in_amt != '0) begin
      case (rot_op_e'(in_op))
        OP_ROR:                 w_in_cmode = 2'd1;
        OP_ROL:                 w_in_cmode = 2'd2;
        OP_SRL, OP_SLL, OP_SRA: w_in_cmode = 2'd3;
        default:                w_in_cmode = 2'd0;
      endcase
    end
  end

  always_comb begin
    case (r_s1_cmode)
      2'd1:    w_s2_carry = w_s2_result[WIDTH-1];
      2'd2:    w_s2_carry = w_s2_result[0];
      2'd3:    w_s2_carry = r_s1_cbit;
      default: w_s2_carry = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_cmode  <= 2'd0;
      r_s1_cbit   <= 1'b0;
      r_out_zero  <= 1'b0;
      r_out_carry <= 1'b0;
    end else begin
      if (w_s1_ready && in_valid) begin
        r_s1_cmode <= w_in_cmode;
        r_s1_cbit  <= w_in_cbit;
      end
      if (w_s2_ready && r_s1_valid) begin
        r_out_zero  <= (w_s2_result == '0);
        r_out_carry <= w_s2_carry;
      end
    end
  end

  assign out_zero  = r_out_zero;
  assign out_carry = r_out_carry;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_data    <= '0;
      r_s1_amt_lo  <= '0;
      r_s1_fill    <= 1'b0;
      r_s1_rotate  <= 1'b0;
      r_s1_reverse <= 1'b0;
      r_s1_tag     <= '0;
      r_s2_valid   <= 1'b0;
      r_out_data   <= '0;
      r_out_tag    <= '0;
    end else begin
      if (w_s1_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_data    <= w_s1_chain[SPLIT];
          r_s1_amt_lo  <= w_in_amt[SPLIT-1:0];
          r_s1_fill    <= w_in_fill;
          r_s1_rotate  <= w_in_rotate;
          r_s1_reverse <= w_in_reverse;
          r_s1_tag     <= in_tag;
        end
      end
      if (w_s2_ready) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_s2_result;
          r_out_tag  <= r_s1_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_rotate_shift_pipe.sv
// Randomised and directed bench for rotate_shift_pipe against an arithmetic
// reference model; flag checks are active when ROT_FLAGS_EN is defined.
module tb_rotate_shift_pipe;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a;
  logic [AW-1:0] in_amt;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
`ifdef ROT_FLAGS_EN
  logic          out_zero;
  logic          out_carry;
`endif

  always #5 clk = ~clk;

  rotate_shift_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_amt   (in_amt),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
`ifdef ROT_FLAGS_EN
    .out_zero (out_zero),
    .out_carry(out_carry),
`endif
    .out_tag  (out_tag)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the operation definitions.
  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input int amt);
    case (op)
      3'd0: return (a >> amt) | (a << (32 - amt));
      3'd1: return (a << amt) | (a >> (32 - amt));
      3'd2: return a >> amt;
      3'd3: return a << amt;
      3'd4: return $signed(a) >>> amt;
      default: return a;
    endcase
  endfunction

  function automatic logic model_carry(input logic [2:0] op, input logic [31:0] a, input int amt);
    logic [31:0] r;
    r = model_res(op, a, amt);
    if (amt == 0) return 1'b0;
    case (op)
      3'd0:       return r[31];
      3'd1:       return r[0];
      3'd2, 3'd4: return a[amt-1];
      3'd3:       return a[32-amt];
      default:    return 1'b0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    logic        z;
    logic        c;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  tag_log[$];
  logic        hold_prev = 1'b0;
  logic [31:0] hold_d;
  logic [3:0]  hold_t;

  // Single compare process: scoreboard, output stability and phantom checks.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_data", 64'(out_data), 64'(hold_d));
        check("hold_tag", 64'(out_tag), 64'(hold_t));
      end
      if (sb.size() == 0) begin
        check("no_phantom_out", 64'(out_valid), 64'(0));
      end else if (out_valid && out_ready) begin
        exp_t e;
        e = sb.pop_front();
        tag_log.push_back(out_tag);
        check("out_data", 64'(out_data), 64'(e.d));
        check("out_tag", 64'(out_tag), 64'(e.t));
`ifdef ROT_FLAGS_EN
        check("out_zero", 64'(out_zero), 64'(e.z));
        check("out_carry", 64'(out_carry), 64'(e.c));
`endif
      end
      if (in_valid && in_ready) begin
        exp_t n;
        n.d = model_res(in_op, in_a, int'(in_amt));
        n.t = in_tag;
        n.z = (n.d == 32'd0);
        n.c = model_carry(in_op, in_a, int'(in_amt));
        sb.push_back(n);
      end
      hold_prev = out_valid && !out_ready;
      hold_d    = out_data;
      hold_t    = out_tag;
    end
  end

  // Drive one op (caller is at posedge+1) and return once it has been accepted.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [4:0] amt, input logic [3:0] tag);
    logic accepted;
    accepted = 1'b0;
    in_op = op; in_a = a; in_amt = amt; in_tag = tag; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    check("send_accept", 64'(accepted), 64'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Directed op with a hand-computed result; also pins the model and latency.
  task automatic run_one(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [4:0] amt, input logic [3:0] tag,
                         input logic [31:0] exp_d, input logic exp_c);
    int lat;
    check({name, "_model"}, 64'(model_res(op, a, int'(amt))), 64'(exp_d));
    check({name, "_model_carry"}, 64'(model_carry(op, a, int'(amt))), 64'(exp_c));
    send(op, a, amt, tag);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      lat = k;
      if (out_valid) break;
    end
    check({name, "_latency"}, 64'(lat), 64'(2));
    check({name, "_data"}, 64'(out_data), 64'(exp_d));
`ifdef ROT_FLAGS_EN
    check({name, "_carry"}, 64'(out_carry), 64'(exp_c));
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_low;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_amt = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_data", 64'(out_data), 64'(0));
    check("reset_out_tag", 64'(out_tag), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    run_one("ror1",     3'd0, 32'h8000_0001, 5'd1,  4'd1, 32'hC000_0000, 1'b1);
    run_one("rol4",     3'd1, 32'h1234_5678, 5'd4,  4'd2, 32'h2345_6781, 1'b1);
    run_one("sll4",     3'd3, 32'h1234_5678, 5'd4,  4'd3, 32'h2345_6780, 1'b1);
    run_one("sra31",    3'd4, 32'h8000_0000, 5'd31, 4'd4, 32'hFFFF_FFFF, 1'b0);
    run_one("srl31",    3'd2, 32'h8000_0000, 5'd31, 4'd5, 32'h0000_0001, 1'b0);
    run_one("srl1",     3'd2, 32'h0000_0001, 5'd1,  4'd6, 32'h0000_0000, 1'b1);
    run_one("reserved", 3'd6, 32'hDEAD_BEEF, 5'd5,  4'd7, 32'hDEAD_BEEF, 1'b0);

    for (int a = 0; a < 32; a++) send(3'd0, $urandom, 5'(a), 4'(a));
    for (int op = 0; op < 8; op++) send(3'(op), $urandom, 5'd0, 4'(op));
    idle(5);

    // Eight tagged ops with the output stalled in cycles 3..6.
    tag_log.delete();
    seen_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(3'($urandom_range(0, 4)), $urandom, 5'($urandom_range(0, 31)), 4'(i));
      end
      begin
        for (int j = 0; j < 20; j++) begin
          out_ready = !(j >= 3 && j <= 6);
          @(negedge clk);
          if (!in_ready) seen_low = 1'b1;
          @(posedge clk);
          #1;
        end
      end
    join
    check("stall_in_ready_fell", 64'(seen_low), 64'(1));
    check("stall_count", 64'(tag_log.size()), 64'(8));
    for (int i = 0; i < tag_log.size() && i < 8; i++) check("stall_tag_order", 64'(tag_log[i]), 64'(i));

    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_a      = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      in_amt    = 5'($urandom_range(0, 31));
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    idle(6);
    check("drain_empty", 64'(sb.size()), 64'(0));

    // Reset with two ops held in the pipe.
    out_ready = 1'b0;
    send(3'd0, 32'h1111_2222, 5'd3, 4'd10);
    send(3'd1, 32'h3333_4444, 5'd4, 4'd11);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", 64'(out_valid), 64'(0));
    check("rst_mid_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    idle(4);
    run_one("post_rst", 3'd2, 32'hF000_000F, 5'd4, 4'd12, 32'h0F00_0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
